axi4lite_master: RTL and testbench

//  Command-driven AXI4-Lite master; sits directly upstream of the 2-bit-addr / 8-bit-data register slave.

---
 rtl/axi4lite_pkg.sv | 26 ++
 rtl/axi4lite_watchdog.sv | 37 +++
 rtl/axi4lite_master.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the command-driven AXI4-Lite master.
// Holds the bus widths of the downstream register slave, the AXI response
// codes and the master's state encoding.
package axi4lite_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Code reported to the command side when the watchdog gives up.
    localparam logic [1:0] RESP_TIMEOUT = RESP_SLVERR;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi4lite_watchdog.sv
// Per-phase watchdog for the AXI4-Lite master.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : restart the count (asserted on every master state change)
//   i_enable       : count this cycle (master is waiting on the slave)
//   o_expire       : the phase has now waited TIMEOUT_CYCLES cycles
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module axi4lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Expiry is flagged during the last waiting cycle so the abort edge is the
    // TIMEOUT_CYCLES-th edge spent in the phase.
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT_CYCLES > 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/axi4lite_master.sv
// Command-driven AXI4-Lite master.
// Converts one command (read/write, addr, data, strobe) into a full AXI4-Lite
// transaction and returns the result on a response port held until accepted.
// Ports:
//   m_axi_aclk, m_axi_aresetn        : clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb : command port (ready only when idle)
//   rsp_valid/ready/rdata/resp/timeout     : response port
//   m_axi_aw*/w*/b*/ar*/r*           : AXI4-Lite master channels
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    mst_state_e        r_state;
    mst_state_e        w_state_nxt;
    logic              w_abort;
    logic              w_expire;
    logic              w_wd_en;

    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wstrb;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_bready;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_resp;
    logic              r_rsp_timeout;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_aw_hs = r_awvalid & m_axi_awready;
    assign w_w_hs  = r_wvalid  & m_axi_wready;
    assign w_b_hs  = r_bready  & m_axi_bvalid;
    assign w_ar_hs = r_arvalid & m_axi_arready;
    assign w_r_hs  = r_rready  & m_axi_rvalid;

    assign w_wd_en = (r_state == ST_WR_AW_W) || (r_state == ST_WR_B) ||
                     (r_state == ST_RD_AR)   || (r_state == ST_RD_R);

    axi4lite_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (m_axi_aclk),
        .i_rst_n  (m_axi_aresetn),
        .i_clear  (w_state_nxt != r_state),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    // A handshake completing on the expiry edge wins over the abort, so a
    // genuine slave response is never discarded.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_nxt = cmd_write ? ST_WR_AW_W : ST_RD_AR;
            end
            ST_WR_AW_W: begin
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_state_nxt = ST_WR_B;
                end else if (w_expire) begin
                    w_state_nxt = ST_RSP;
                    w_abort     = 1'b1;
                end
            end
            ST_WR_B: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_RSP;
                end else if (w_expire) begin
                    w_state_nxt = ST_RSP;
                    w_abort     = 1'b1;
                end
            end
            ST_RD_AR: begin
                // The slave may present R together with AR accept; the data
                // is captured then and rready completes its handshake in RSP.
                if (w_ar_hs) begin
                    w_state_nxt = m_axi_rvalid ? ST_RSP : ST_RD_R;
                end else if (w_expire) begin
                    w_state_nxt = ST_RSP;
                    w_abort     = 1'b1;
                end
            end
            ST_RD_R: begin
                if (w_r_hs) begin
                    w_state_nxt = ST_RSP;
                end else if (w_expire) begin
                    w_state_nxt = ST_RSP;
                    w_abort     = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            r_state       <= ST_IDLE;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_bready      <= 1'b0;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_r_hs) r_rready <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_state_nxt == ST_WR_B) r_bready <= 1'b1;
                end
                ST_WR_B: begin
                    if (w_b_hs) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_resp    <= m_axi_bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                ST_RD_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        if (m_axi_rvalid) begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= m_axi_rdata;
                            r_rsp_resp    <= m_axi_rresp;
                            r_rsp_timeout <= 1'b0;
                        end
                    end
                end
                ST_RD_R: begin
                    if (w_r_hs) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= m_axi_rdata;
                        r_rsp_resp    <= m_axi_rresp;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase

            if (w_abort) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= RESP_TIMEOUT;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: directed commands against a small behavioural
// register slave (4 x 8-bit) with knobs for stalls, error responses and a
// missing write response.
module tb_axi4lite_master;

    logic       clk;
    logic       aresetn;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_wstrb;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [1:0] m_axi_awaddr, m_axi_araddr, m_axi_bresp, m_axi_rresp;
    logic       m_axi_awvalid, m_axi_awready, m_axi_wstrb, m_axi_wvalid, m_axi_wready;
    logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic       m_axi_rvalid, m_axi_rready;
    logic [7:0] m_axi_wdata, m_axi_rdata;

    // slave knobs
    logic stall_aw, stall_ar, no_bresp, err_resp;

    int n_chk;
    int n_bad;

    axi4lite_master #(.TIMEOUT_CYCLES(8)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural register slave ----------------
    logic [7:0] s_mem [4];
    logic       s_aw_got;
    logic [1:0] s_awaddr;

    assign m_axi_awready = !s_aw_got && !m_axi_bvalid && !stall_aw;
    assign m_axi_wready  = s_aw_got;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s_aw_got      <= 1'b0;
            s_awaddr      <= 2'd0;
            m_axi_bvalid  <= 1'b0;
            m_axi_bresp   <= 2'b00;
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rdata   <= 8'h00;
            m_axi_rresp   <= 2'b00;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                s_aw_got <= 1'b1;
                s_awaddr <= m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wstrb) s_mem[s_awaddr] <= m_axi_wdata;
                s_aw_got <= 1'b0;
                if (!no_bresp) begin
                    m_axi_bvalid <= 1'b1;
                    m_axi_bresp  <= err_resp ? 2'b10 : 2'b00;
                end
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            // AR accept and R data appear on the same edge
            m_axi_arready <= m_axi_arvalid && !m_axi_arready && !m_axi_rvalid && !stall_ar;
            if (m_axi_arvalid && !m_axi_arready && !m_axi_rvalid && !stall_ar) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= s_mem[m_axi_araddr];
                m_axi_rresp  <= err_resp ? 2'b10 : 2'b00;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Issue one command, wait for its response (bounded), optionally hold
    // rsp_ready low for 'hold' cycles while watching stability, then accept.
    task automatic do_cmd(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          input logic s, input int hold,
                          output logic [7:0] rd, output logic [1:0] rs, output logic to,
                          output int lat, output int bcyc);
        int  guard;
        logic ok;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat  = 1;
        bcyc = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            if (m_axi_bready) bcyc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) check("rsp_wait", 0, 1);
        rd = rsp_rdata;
        rs = rsp_resp;
        to = rsp_timeout;
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs ||
                    rsp_timeout !== to || cmd_ready !== 1'b0) ok = 1'b0;
            end
            check("hold_stable", ok, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic [1:0] rs;
    logic       to;
    int         lat, bcyc;
    logic [7:0] pat [4];

    initial begin
        n_chk = 0;
        n_bad = 0;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'h00;
        cmd_wstrb = 1'b0;
        rsp_ready = 1'b0;
        stall_aw = 1'b0;
        stall_ar = 1'b0;
        no_bresp = 1'b0;
        err_resp = 1'b0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 0);
        check("rst_payload", {m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_wstrb}, 0);
        check("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;

        // basic write then read
        do_cmd(1'b1, 2'd2, 8'hA5, 1'b1, 0, rd, rs, to, lat, bcyc);
        check("wr_resp", {rd, rs, to}, {8'h00, 2'b00, 1'b0});
        check("wr_latency", lat, 4);
        do_cmd(1'b0, 2'd2, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("rd_data", rd, 8'hA5);
        check("rd_resp_to", {rs, to}, 3'b000);
        check("rd_latency", lat, 3);

        // fill all four registers and read back in order
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b1, 2'(i), pat[i], 1'b1, 0, rd, rs, to, lat, bcyc);
            check("fill_resp", {rs, to}, 3'b000);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 2'(i), 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
            check("fill_rd", rd, pat[i]);
        end

        // strobe low: register keeps its value
        do_cmd(1'b1, 2'd1, 8'h99, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("nostrb_wr_resp", rs, 2'b00);
        do_cmd(1'b0, 2'd1, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("nostrb_rd", {rd, rs}, {8'h22, 2'b00});

        // response held back by rsp_ready low
        do_cmd(1'b0, 2'd3, 8'h00, 1'b0, 10, rd, rs, to, lat, bcyc);
        check("hold_rd", rd, 8'h44);

        // slave error codes pass through untouched
        err_resp = 1'b1;
        do_cmd(1'b0, 2'd0, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("err_rd", {rd, rs, to}, {8'h11, 2'b10, 1'b0});
        do_cmd(1'b1, 2'd0, 8'h11, 1'b1, 0, rd, rs, to, lat, bcyc);
        check("err_wr", {rd, rs, to}, {8'h00, 2'b10, 1'b0});
        err_resp = 1'b0;

        // missing write response: 8 cycles in WR_B then abort
        no_bresp = 1'b1;
        do_cmd(1'b1, 2'd3, 8'h55, 1'b1, 0, rd, rs, to, lat, bcyc);
        check("wto_rsp", {rd, rs, to}, {8'h00, 2'b10, 1'b1});
        check("wto_bready_cycles", bcyc, 8);
        check("wto_latency", lat, 11);
        no_bresp = 1'b0;

        // read address never accepted: 8 cycles in RD_AR then abort
        stall_ar = 1'b1;
        do_cmd(1'b0, 2'd1, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("rto_rsp", {rd, rs, to}, {8'h00, 2'b10, 1'b1});
        check("rto_latency", lat, 9);
        check("rto_arvalid_dropped", m_axi_arvalid, 0);
        stall_ar = 1'b0;

        // normal traffic after timeouts
        do_cmd(1'b0, 2'd3, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("post_to_rd", {rd, rs, to}, {8'h55, 2'b00, 1'b0});

        // reset in the middle of a write
        stall_aw = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd1;
        cmd_wdata = 8'h66;
        cmd_wstrb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_awvalid", m_axi_awvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 0);
        check("midrst_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        aresetn  = 1'b1;
        stall_aw = 1'b0;
        do_cmd(1'b1, 2'd0, 8'h5A, 1'b1, 0, rd, rs, to, lat, bcyc);
        check("postrst_wr", {rs, to, lat[3:0]}, {2'b00, 1'b0, 4'd4});
        do_cmd(1'b0, 2'd0, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("postrst_rd", rd, 8'h5A);
        do_cmd(1'b0, 2'd1, 8'h00, 1'b0, 0, rd, rs, to, lat, bcyc);
        check("abandoned_wr", rd, 8'h22);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
